// File: rtl/memory_pkg.sv
// memory_pkg: shared L1 dcache geometry constants and lookup/response types
package memory_pkg;
  localparam int DCACHE_L1_ASSOCIATIVITY = 4;
  localparam int DCACHE_L1_SETS = 64;
  localparam int DCACHE_L1_TAG_W = 20;
  localparam int DCACHE_L1_IDX_W = $clog2(DCACHE_L1_SETS);
  typedef logic [DCACHE_L1_TAG_W-1:0] dcache_tag_t;
  typedef logic [DCACHE_L1_ASSOCIATIVITY-1:0] valid_vec_t;
  typedef logic [DCACHE_L1_ASSOCIATIVITY-1:0] dirty_vec_t;
  typedef logic [DCACHE_L1_ASSOCIATIVITY-1:0] hit_vec_t;
  typedef logic [DCACHE_L1_ASSOCIATIVITY-1:0] repl_vec_t;
  typedef struct packed {
    logic [DCACHE_L1_IDX_W-1:0] idx;
    hit_vec_t hit_vec;
    logic hit;
    logic multihit;
    repl_vec_t victim_vec;
    logic victim_dirty;
    dcache_tag_t victim_tag;
  } d1_comp_rsp_t;
endpackage

// File: rtl/d1_repl_state.sv
// d1_repl_state: per-set replacement state and full-set victim pointer (round-robin, or tree PLRU when DCACHE_PLRU_EN is defined)
module d1_repl_state
  import memory_pkg::*;
#(
  parameter int N_WAY = DCACHE_L1_ASSOCIATIVITY,
  parameter int N_SETS = DCACHE_L1_SETS,
  localparam int IDX_W = $clog2(N_SETS),
  localparam int WW = $clog2(N_WAY)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             upd_i,
  input  logic [WW-1:0]    way_i,
  output logic [WW-1:0]    ptr_o
);
`ifdef DCACHE_PLRU_EN
  localparam int SW = N_WAY - 1;
`else
  localparam int SW = WW;
`endif
  logic [SW-1:0] st_q [N_SETS];
  logic [SW-1:0] row;
  logic [SW-1:0] row_d;
  assign row = st_q[idx_i];
`ifdef DCACHE_PLRU_EN
  // walk the tree from the root; a zero bit steers toward the lower half
  always_comb begin
    int n;
    n = 1;
    for (int l = 0; l < WW; l++) n = 2 * n + int'(row[n-1]);
    ptr_o = WW'(n - N_WAY);
  end
  // touch: every node on the path to way_i points away from it
  always_comb begin
    int n;
    n = 1;
    row_d = row;
    for (int l = 0; l < WW; l++) begin
      n = (1 << l) | (int'(way_i) >> (WW - l));
      row_d[n-1] = ~way_i[WW-1-l];
    end
  end
`else
  assign ptr_o = row;
  // next pointer follows the way just replaced, wrapping naturally at N_WAY
  always_comb row_d = way_i + WW'(1);
`endif
  // state array: cleared by reset or flush, one row written per update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) for (int s = 0; s < N_SETS; s++) st_q[s] <= '0;
    else if (flush_i) for (int s = 0; s < N_SETS; s++) st_q[s] <= '0;
    else if (upd_i) st_q[idx_i] <= row_d;
  end
endmodule

// File: rtl/d1_pipe_comp_block.sv
// d1_pipe_comp_block: registered dcache tag compare with hit/multihit and victim selection; DCACHE_PLRU_EN selects PLRU replacement
module d1_pipe_comp_block
  import memory_pkg::*;
#(
  parameter int N_WAY = DCACHE_L1_ASSOCIATIVITY,
  parameter int N_SETS = DCACHE_L1_SETS,
  parameter int TAG_W = DCACHE_L1_TAG_W,
  localparam int IDX_W = $clog2(N_SETS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IDX_W-1:0]       req_idx_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic [N_WAY*TAG_W-1:0] tag_vec_i,
  input  logic [N_WAY-1:0]       valid_vec_i,
  input  logic [N_WAY-1:0]       dirty_vec_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IDX_W-1:0]       rsp_idx_o,
  output logic [N_WAY-1:0]       hit_vec_o,
  output logic                   hit_o,
  output logic                   multihit_o,
  output logic [N_WAY-1:0]       victim_vec_o,
  output logic                   victim_dirty_o,
  output logic [TAG_W-1:0]       victim_tag_o
);
  localparam int WW = $clog2(N_WAY);
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [N_WAY-1:0] hit_vec;
    logic hit;
    logic multihit;
    logic [N_WAY-1:0] victim_vec;
    logic victim_dirty;
    logic [TAG_W-1:0] victim_tag;
  } rsp_t;
  rsp_t rsp_q, rsp_d;
  logic rsp_valid_q, rsp_valid_d;
  logic accept, upd_en;
  logic [N_WAY-1:0] hit_vec;
  logic [WW-1:0] hit_way, victim_way, upd_way, ptr;
  assign req_ready_o = !flush_i & (!rsp_valid_q | rsp_ready_i);
  assign accept = req_valid_i & req_ready_o;
  // per-way compare; descending scan leaves the lowest hit and lowest invalid way
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    victim_way = ptr;
    for (int k = N_WAY - 1; k >= 0; k--) begin
      hit_vec[k] = valid_vec_i[k] & (tag_vec_i[k*TAG_W +: TAG_W] == tag_i);
      if (hit_vec[k]) hit_way = WW'(k);
      if (!valid_vec_i[k]) victim_way = WW'(k);
    end
  end
  // next response contents; victim fields forced to zero on any hit
  always_comb begin
    rsp_d.idx = req_idx_i;
    rsp_d.hit_vec = hit_vec;
    rsp_d.hit = |hit_vec;
    rsp_d.multihit = |(hit_vec & (hit_vec - N_WAY'(1)));
    rsp_d.victim_vec = rsp_d.hit ? '0 : N_WAY'(1) << victim_way;
    rsp_d.victim_dirty = !rsp_d.hit & dirty_vec_i[victim_way];
    rsp_d.victim_tag = rsp_d.hit ? '0 : tag_vec_i[int'(victim_way)*TAG_W +: TAG_W];
    rsp_valid_d = flush_i ? 1'b0 : accept ? 1'b1 : rsp_ready_i ? 1'b0 : rsp_valid_q;
  end
`ifdef DCACHE_PLRU_EN
  assign upd_en = accept & !rsp_d.multihit;
  assign upd_way = rsp_d.hit ? hit_way : victim_way;
`else
  assign upd_en = accept & !rsp_d.hit & (&valid_vec_i);
  assign upd_way = victim_way;
`endif
  d1_repl_state #(.N_WAY(N_WAY), .N_SETS(N_SETS)) u_repl (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .idx_i  (req_idx_i),
    .upd_i  (upd_en),
    .way_i  (upd_way),
    .ptr_o  (ptr)
  );
  // output register: loaded on accept, held until consumed, dropped by flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (accept) rsp_q <= rsp_d;
    end
  end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_idx_o = rsp_q.idx;
  assign hit_vec_o = rsp_q.hit_vec;
  assign hit_o = rsp_q.hit;
  assign multihit_o = rsp_q.multihit;
  assign victim_vec_o = rsp_q.victim_vec;
  assign victim_dirty_o = rsp_q.victim_dirty;
  assign victim_tag_o = rsp_q.victim_tag;
endmodule
